// File: rtl/sad_search_ctrl.sv
// Full-search motion-estimation controller: raster-issues candidates to SAD_Cal and keeps the minimum SAD and its vector.
// Latency: one candidate per cycle while tags are free; done follows the last result by two cycles.
// Backpressure: issue stalls when the outstanding-tag FIFO is full and no result frees a slot.

// Outstanding-candidate tag FIFO.
// Latency: a push is visible at pop_dat the cycle after it is written; pop_dat shows the head combinationally.
// Backpressure: a push is accepted when not full, or when full with a pop in the same cycle.
module sad_tag_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_vld && !empty;
        do_push  = push_vld && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        pop_dat  = mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end
endmodule

// Search controller top.
// Latency: first cal_en one cycle after start is accepted; done two cycles after the final sad_vld.
// Backpressure: cal_en gaps appear only while TAG_DEPTH candidates are awaiting results.
module sad_search_ctrl #(
    parameter int DWIDTH    = 8,
    parameter int RANGE     = 4,
    parameter int MVW       = 6,
    parameter int TAG_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              cal_en,
    output logic [MVW-1:0]    cand_x,
    output logic [MVW-1:0]    cand_y,
    input  logic [DWIDTH+7:0] sad,
    input  logic              sad_vld,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH+7:0] best_sad,
    output logic [MVW-1:0]    best_mvx,
    output logic [MVW-1:0]    best_mvy,
    output logic              err
);
    localparam int SW    = DWIDTH + 8;
    localparam int TOTAL = (2*RANGE + 1) * (2*RANGE + 1);
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [MVW-1:0] R_POS    = MVW'(RANGE);
    localparam logic [MVW-1:0] R_NEG    = MVW'(-RANGE);
    localparam logic [CW-1:0]  LAST_IDX = CW'(TOTAL - 1);
    localparam logic [CW-1:0]  TOTAL_C  = CW'(TOTAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [MVW-1:0] pos_x_q, pos_x_d;
    logic [MVW-1:0] pos_y_q, pos_y_d;
    logic [CW-1:0]  iss_cnt_q, iss_cnt_d;
    logic [CW-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic           first_q, first_d;
    logic           err_q, err_d;
    logic [SW-1:0]  best_sad_q, best_sad_d;
    logic [MVW-1:0] best_mvx_q, best_mvx_d;
    logic [MVW-1:0] best_mvy_q, best_mvy_d;
    logic           cal_en_q, cal_en_d;
    logic [MVW-1:0] cand_x_q, cand_x_d;
    logic [MVW-1:0] cand_y_q, cand_y_d;

    logic             start_acc;
    logic             pop;
    logic             issue;
    logic             fifo_full;
    logic             fifo_empty;
    logic [2*MVW-1:0] tag_dat;

    sad_tag_fifo #(
        .W     (2*MVW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (issue),
        .push_dat ({pos_x_q, pos_y_q}),
        .pop_vld  (pop),
        .pop_dat  (tag_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: if (issue && iss_cnt_q == LAST_IDX) state_d = S_DRAIN;
            S_DRAIN: if (rcv_cnt_q == TOTAL_C && fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
    end

    // A result arriving in the same cycle frees a slot, so a full FIFO still issues.
    always_comb begin
        start_acc = (state_q == S_IDLE) && start;
        pop       = sad_vld && !fifo_empty;
        issue     = (state_q == S_ISSUE) && (!fifo_full || pop);

        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        iss_cnt_d  = iss_cnt_q;
        rcv_cnt_d  = rcv_cnt_q;
        first_d    = first_q;
        err_d      = err_q;
        best_sad_d = best_sad_q;
        best_mvx_d = best_mvx_q;
        best_mvy_d = best_mvy_q;
        cal_en_d   = issue;
        cand_x_d   = issue ? pos_x_q : cand_x_q;
        cand_y_d   = issue ? pos_y_q : cand_y_q;

        if (start_acc) begin
            pos_x_d   = R_NEG;
            pos_y_d   = R_NEG;
            iss_cnt_d = '0;
            rcv_cnt_d = '0;
            err_d     = 1'b0;
            first_d   = 1'b1;
        end

        if (issue) begin
            iss_cnt_d = iss_cnt_q + CW'(1);
            if (pos_x_q == R_POS) begin
                pos_x_d = R_NEG;
                pos_y_d = pos_y_q + MVW'(1);
            end else begin
                pos_x_d = pos_x_q + MVW'(1);
            end
        end

        // Strict compare keeps the raster-first candidate on ties.
        if (pop) begin
            rcv_cnt_d = rcv_cnt_q + CW'(1);
            if (first_q || sad < best_sad_q) begin
                best_sad_d = sad;
                best_mvx_d = tag_dat[2*MVW-1:MVW];
                best_mvy_d = tag_dat[MVW-1:0];
                first_d    = 1'b0;
            end
        end

        if (sad_vld && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            iss_cnt_q  <= '0;
            rcv_cnt_q  <= '0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            best_sad_q <= '0;
            best_mvx_q <= '0;
            best_mvy_q <= '0;
            cal_en_q   <= 1'b0;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            iss_cnt_q  <= iss_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
            first_q    <= first_d;
            err_q      <= err_d;
            best_sad_q <= best_sad_d;
            best_mvx_q <= best_mvx_d;
            best_mvy_q <= best_mvy_d;
            cal_en_q   <= cal_en_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
        end
    end

    assign cal_en   = cal_en_q;
    assign cand_x   = cand_x_q;
    assign cand_y   = cand_y_q;
    assign best_sad = best_sad_q;
    assign best_mvx = best_mvx_q;
    assign best_mvy = best_mvy_q;
    assign err      = err_q;
endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: behavioural SAD_Cal with programmable latency plus a done-triggered scoreboard.
module tb_sad_search_ctrl;
    localparam int MVW       = 6;
    localparam int RANGE     = 4;
    localparam int TAG_DEPTH = 16;
    localparam int SW        = 16;
    localparam int TOTAL     = (2*RANGE + 1) * (2*RANGE + 1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           cal_en;
    logic [MVW-1:0] cand_x, cand_y, best_mvx, best_mvy;
    logic [SW-1:0]  sad = '0;
    logic           sad_vld = 1'b0;
    logic           busy, done, err;
    logic [SW-1:0]  best_sad;

    sad_search_ctrl #(
        .DWIDTH    (8),
        .RANGE     (RANGE),
        .MVW       (MVW),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cal_en   (cal_en),
        .cand_x   (cand_x),
        .cand_y   (cand_y),
        .sad      (sad),
        .sad_vld  (sad_vld),
        .busy     (busy),
        .done     (done),
        .best_sad (best_sad),
        .best_mvx (best_mvx),
        .best_mvy (best_mvy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int            due;
        logic [SW-1:0] val;
    } pend_t;

    typedef struct {
        logic [SW-1:0]  sad;
        logic [MVW-1:0] mx;
        logic [MVW-1:0] my;
        bit             full_rate;
    } exp_t;

    pend_t pend_q[$];
    exp_t  exp_q[$];

    int mode = 0;
    int lat = 5;
    int pulses = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int outst = 0;
    int max_out = 0;
    bit spur_req = 1'b0;
    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] sad_model(input logic [MVW-1:0] cx, input logic [MVW-1:0] cy);
        int x, y, ax, ay, r;
        x  = int'($signed(cx));
        y  = int'($signed(cy));
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        case (mode)
            0:       r = 10 + ax + ay;
            1:       r = 'h1234;
            2:       r = 'hFFFF;
            default: r = (x == 3 && y == -2) ? 5 : 50 + ax + ay;
        endcase
        return SW'(r);
    endfunction

    // Behavioural SAD_Cal: each cal_en produces one result lat cycles later, in order.
    always @(negedge clk) begin
        pend_t p;
        sad_vld = 1'b0;
        sad     = '0;
        if (spur_req) begin
            sad_vld  = 1'b1;
            spur_req = 1'b0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p       = pend_q.pop_front();
            sad_vld = 1'b1;
            sad     = p.val;
            outst--;
        end
        if (cal_en) begin
            p.due = cyc + lat;
            p.val = sad_model(cand_x, cand_y);
            pend_q.push_back(p);
            outst++;
            pulses++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (outst > max_out) max_out = outst;
        end
    end

    // Scoreboard monitor: every done pops one expected search result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no done (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("best_sad", 32'(best_sad), 32'(e.sad));
                chk("best_mvx", 32'(best_mvx), 32'(e.mx));
                chk("best_mvy", 32'(best_mvy), 32'(e.my));
                chk("err_at_done", 32'(err), 32'd0);
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("cal_en_pulses", 32'(pulses), 32'(TOTAL));
                chk("issue_full_rate", 32'(last_cyc - first_cyc + 1 == TOTAL), 32'(e.full_rate));
                chk("outstanding_bound", 32'(max_out <= TAG_DEPTH), 32'd1);
            end
        end
    end

    task automatic wait_done();
        int b;
        int n;
        b = done_seen;
        n = 0;
        while (done_seen == b && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == b) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected done", n);
        end
        @(negedge clk);
        chk("done_single_cycle", 32'(done), 32'd0);
    endtask

    task automatic run_search(input int m, input int l, input int es, input int ex, input int ey,
                              input bit fr, input bit poke);
        exp_t e;
        mode      = m;
        lat       = l;
        pulses    = 0;
        first_cyc = -1;
        last_cyc  = -1;
        outst     = 0;
        max_out   = 0;
        e.sad       = SW'(es);
        e.mx        = MVW'(ex);
        e.my        = MVW'(ey);
        e.full_rate = fr;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_cleared_by_start", 32'(err), 32'd0);
        if (poke) begin
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({cal_en, cand_x, cand_y, busy, done, err}), 32'd0);
        chk("reset_best", 32'({best_sad, best_mvx, best_mvy}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Distance-weighted SAD, latency 5: minimum at the origin.
        run_search(0, 5, 10, 0, 0, 1'b1, 1'b0);

        // Result with no candidate outstanding.
        spur_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("err_spurious", 32'(err), 32'd1);
        chk("best_sad_hold", 32'(best_sad), 32'd10);
        chk("best_mv_hold", 32'({best_mvx, best_mvy}), 32'd0);

        run_search(1, 5, 'h1234, -4, -4, 1'b1, 1'b0);
        run_search(2, 5, 'hFFFF, -4, -4, 1'b1, 1'b0);
        run_search(3, 20, 5, 3, -2, 1'b0, 1'b0);

        // Abort mid-issue via reset.
        mode  = 0;
        lat   = 5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("cal_en_before_abort", 32'(cal_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({cal_en, cand_x, cand_y, busy, done, err}), 32'd0);
        chk("abort_best", 32'({best_sad, best_mvx, best_mvy}), 32'd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("err_after_release", 32'(err), 32'd0);

        run_search(1, 5, 'h1234, -4, -4, 1'b1, 1'b1);

        chk("no_pending_expect", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
